// File: rtl/cpu_pkg.sv
// Shared CPU constants and state encodings for the move-wide sequencer.
//   HW_W    halfword width
//   NUM_HW  halfwords per word
//   REG_AW  register address width
//   wil_state_t  wide_imm_loader FSM states
package cpu_pkg;

    localparam int unsigned HW_W    = 16;
    localparam int unsigned NUM_HW  = 4;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned WORD_W  = NUM_HW * HW_W;
    localparam int unsigned SHAMT_W = $clog2(NUM_HW);

    typedef enum logic [1:0] {
        WIL_IDLE,
        WIL_MOVZ,
        WIL_MOVK,
        WIL_DONE
    } wil_state_t;

endpackage

// File: rtl/wide_imm_loader_if.sv
// Bus bundle between wide_imm_loader, its requester, the move-wide
// transposer and the register-file write port.
//   start/imm/rd/ready          load request handshake
//   fixed/shamt/clear/tp_out    transposer step and its result
//   wr_en/wr_addr/wr_data       register-file write
//   done                        completion pulse
// slave  : the loader's view; master : the surrounding environment.
interface wide_imm_loader_if
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_HW = cpu_pkg::NUM_HW,
    parameter int unsigned HW_W   = cpu_pkg::HW_W,
    parameter int unsigned REG_AW = cpu_pkg::REG_AW
);
    localparam int unsigned WORD_W  = NUM_HW * HW_W;
    localparam int unsigned SHAMT_W = $clog2(NUM_HW);

    logic                start;
    logic [WORD_W-1:0]   imm;
    logic [REG_AW-1:0]   rd;
    logic                ready;
    logic [HW_W-1:0]     fixed;
    logic [SHAMT_W-1:0]  shamt;
    logic                clear;
    logic [WORD_W-1:0]   tp_out;
    logic                wr_en;
    logic [REG_AW-1:0]   wr_addr;
    logic [WORD_W-1:0]   wr_data;
    logic                done;

    modport slave (
        input  start, imm, rd, tp_out,
        output ready, fixed, shamt, clear, wr_en, wr_addr, wr_data, done
    );

    modport master (
        output start, imm, rd, tp_out,
        input  ready, fixed, shamt, clear, wr_en, wr_addr, wr_data, done
    );

endinterface

// File: rtl/wide_imm_loader_hw_pick.sv
// hw_pick: lowest-set-bit finder over a halfword-presence mask.
//   mask  in   NUM_HW-bit mask of halfwords still to emit
//   idx   out  index of the lowest set bit (0 when mask is empty)
//   any   out  1 when any mask bit is set
module hw_pick #(
    parameter int unsigned NUM_HW = 4
) (
    input  logic [NUM_HW-1:0]         mask,
    output logic [$clog2(NUM_HW)-1:0] idx,
    output logic                      any
);

    localparam int unsigned IDX_W = $clog2(NUM_HW);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int unsigned i = NUM_HW; i > 0; i--) begin
            if (mask[i-1]) begin
                idx = IDX_W'(i - 1);
            end
        end
        any = |mask;
    end

endmodule

// File: rtl/wide_imm_loader.sv
// wide_imm_loader: emits a MOVZ followed by MOVK steps to materialise a
// constant into a register, one transposer step and one register-file write
// per cycle, skipping zero halfwords.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      wide_imm_loader_if.slave (request, transposer, write port, done)
module wide_imm_loader #(
    parameter int unsigned NUM_HW = cpu_pkg::NUM_HW,
    parameter int unsigned HW_W   = cpu_pkg::HW_W,
    parameter int unsigned REG_AW = cpu_pkg::REG_AW
) (
    input  logic               clk,
    input  logic               reset_n,
    wide_imm_loader_if.slave   bus
);
    import cpu_pkg::*;

    localparam int unsigned WORD_W  = NUM_HW * HW_W;
    localparam int unsigned SHAMT_W = $clog2(NUM_HW);

    wil_state_t          state_q, state_d;
    logic [WORD_W-1:0]   imm_q;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [REG_AW-1:0]   rd_q;
    logic [NUM_HW-1:0]   mask_q, mask_d;
    logic [NUM_HW-1:0]   nz_mask;
    logic [NUM_HW-1:0]   mask_rest;
    logic [SHAMT_W-1:0]  idx;
    logic                any;
    logic [WORD_W-1:0]   lane;
    logic                accept;

    hw_pick #(.NUM_HW(NUM_HW)) u_pick (
        .mask (mask_q),
        .idx  (idx),
        .any  (any)
    );

    always_comb begin
        nz_mask = '0;
        for (int unsigned i = 0; i < NUM_HW; i++) begin
            nz_mask[i] = |bus.imm[HW_W*i +: HW_W];
        end
    end

    assign accept    = (state_q == WIL_IDLE) && bus.start;
    // An empty mask (imm == 0) still yields one MOVZ #0 at index 0.
    assign mask_rest = any ? (mask_q & ~(NUM_HW'(1) << idx)) : '0;
    assign lane      = {{(WORD_W-HW_W){1'b0}}, {HW_W{1'b1}}} << (HW_W * idx);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WIL_IDLE;
            imm_q   <= '0;
            rd_q    <= '0;
            acc_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
            if (accept) begin
                imm_q <= bus.imm;
                rd_q  <= bus.rd;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mask_d      = mask_q;
        bus.ready   = 1'b0;
        bus.fixed   = '0;
        bus.shamt   = '0;
        bus.clear   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = rd_q;
        bus.wr_data = '0;
        bus.done    = 1'b0;

        case (state_q)
            WIL_IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) begin
                    mask_d  = nz_mask;
                    state_d = WIL_MOVZ;
                end
            end
            WIL_MOVZ: begin
                bus.clear   = 1'b1;
                bus.fixed   = imm_q[HW_W*idx +: HW_W];
                bus.shamt   = idx;
                bus.wr_en   = 1'b1;
                bus.wr_data = bus.tp_out;
                acc_d       = bus.tp_out;
                mask_d      = mask_rest;
                state_d     = (|mask_rest) ? WIL_MOVK : WIL_DONE;
            end
            WIL_MOVK: begin
                bus.fixed   = imm_q[HW_W*idx +: HW_W];
                bus.shamt   = idx;
                bus.wr_en   = 1'b1;
                // Keep every lane except the one being written this step.
                bus.wr_data = (acc_q & ~lane) | bus.tp_out;
                acc_d       = bus.wr_data;
                mask_d      = mask_rest;
                state_d     = (|mask_rest) ? WIL_MOVK : WIL_DONE;
            end
            WIL_DONE: begin
                bus.done = 1'b1;
                state_d  = WIL_IDLE;
            end
            default: state_d = WIL_IDLE;
        endcase
    end

endmodule
